// File: rtl/serial_sub_pkg.sv
// -----------------------------------------------------------------------------
// serial_sub_pkg
// Shared types and helpers for the bit-serial subtractor.
//   state_t    : controller states IDLE / BUSY / DONE (2-bit encoding)
//   cnt_width  : bit-counter width, max(1, $clog2(width)), so that a
//                1-bit-wide operand still gets a legal 1-bit counter
// -----------------------------------------------------------------------------
package serial_sub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int cnt_width(input int width);
      int w;
      w = $clog2(width);
      if (w < 32'sd1) begin
         w = 32'sd1;
      end else begin
         w = w;
      end
      return w;
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// -----------------------------------------------------------------------------
// full_subtractor
// Single-bit full subtractor cell: computes a - b - borrow_in.
// Ports:
//   a_i      : minuend bit
//   b_i      : subtrahend bit
//   borrow_i : incoming borrow from the less significant bit
//   diff_o   : difference bit
//   borrow_o : outgoing borrow to the more significant bit
// -----------------------------------------------------------------------------
module full_subtractor (
   input  logic a_i,
   input  logic b_i,
   input  logic borrow_i,
   output logic diff_o,
   output logic borrow_o
);

   assign diff_o   = a_i ^ b_i ^ borrow_i;
   // Borrow when b exceeds a outright, or when they are equal and a borrow
   // is already pending.
   assign borrow_o = (~a_i & b_i) | (~(a_i ^ b_i) & borrow_i);

endmodule

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Bit-serial ripple-borrow subtractor, LSB first, one full-subtractor cell.
// An accepted request takes WIDTH BUSY cycles, then one DONE cycle in which
// valid_o pulses; diff_o/borrow_o are held until the next completion.
// Ports:
//   clk      : clock, all state on the rising edge
//   rst      : synchronous active-high reset
//   VPWR/VGND: power pins, only when USE_POWER_PINS is defined
//   start_i  : request, accepted only while ready_o is high
//   a_i, b_i : minuend / subtrahend, sampled at the accepting edge
//   ready_o  : high while idle
//   diff_o   : registered (a - b) mod 2^WIDTH
//   borrow_o : registered final borrow, 1 iff a < b (unsigned)
//   valid_o  : one-cycle pulse marking a new diff_o/borrow_o
// -----------------------------------------------------------------------------
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = 4
) (
`ifdef USE_POWER_PINS
   inout  wire              VPWR,
   inout  wire              VGND,
`endif
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             ready_o,
   output logic [WIDTH-1:0] diff_o,
   output logic             borrow_o,
   output logic             valid_o
);

   localparam int               CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 32'sd1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);

   state_t           r_state;
   state_t           w_state_next;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_diff_sh;
   logic [WIDTH-1:0] r_diff;
   logic [WIDTH-1:0] w_d_msb;
   logic [WIDTH-1:0] w_diff_next;
   logic [CNT_W-1:0] r_cnt;
   logic             r_borrow;
   logic             r_borrow_out;
   logic             r_ready;
   logic             r_valid;
   logic             w_d;
   logic             w_bout;
   logic             w_last;

   full_subtractor u_cell (
      .a_i      (r_a[0]),
      .b_i      (r_b[0]),
      .borrow_i (r_borrow),
      .diff_o   (w_d),
      .borrow_o (w_bout)
   );

   assign w_last = (r_cnt == LAST_CNT);

   // Diff shift register next value: this cycle's bit enters at the MSB.
   always_comb begin
      w_d_msb            = {WIDTH{1'b0}};
      w_d_msb[WIDTH-1]   = w_d;
      w_diff_next        = (r_diff_sh >> 1'b1) | w_d_msb;
   end

   // Controller next-state decode.
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE: begin
            if (start_i) begin
               w_state_next = BUSY;
            end else begin
               w_state_next = IDLE;
            end
         end
         BUSY: begin
            if (w_last) begin
               w_state_next = DONE;
            end else begin
               w_state_next = BUSY;
            end
         end
         DONE:    w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath: operand shifting, borrow chain, counter and result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_a          <= {WIDTH{1'b0}};
         r_b          <= {WIDTH{1'b0}};
         r_diff_sh    <= {WIDTH{1'b0}};
         r_diff       <= {WIDTH{1'b0}};
         r_cnt        <= {CNT_W{1'b0}};
         r_borrow     <= 1'b0;
         r_borrow_out <= 1'b0;
         r_ready      <= 1'b1;
         r_valid      <= 1'b0;
      end else begin
         // Handshake flags are registered from the next state so they line
         // up exactly with the state they describe.
         r_ready <= (w_state_next == IDLE);
         r_valid <= (w_state_next == DONE);
         case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_a       <= a_i;
                  r_b       <= b_i;
                  r_diff_sh <= {WIDTH{1'b0}};
                  r_borrow  <= 1'b0;
                  r_cnt     <= {CNT_W{1'b0}};
               end
            end
            BUSY: begin
               r_a       <= r_a >> 1'b1;
               r_b       <= r_b >> 1'b1;
               r_diff_sh <= w_diff_next;
               r_borrow  <= w_bout;
               r_cnt     <= r_cnt + CNT_ONE;
               // Last bit: publish the full vector including this bit.
               if (w_last) begin
                  r_diff       <= w_diff_next;
                  r_borrow_out <= w_bout;
               end
            end
            default: begin
               r_cnt <= r_cnt;
            end
         endcase
      end
   end

   assign ready_o  = r_ready;
   assign valid_o  = r_valid;
   assign diff_o   = r_diff;
   assign borrow_o = r_borrow_out;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
// Scoreboard bench for serial_subtractor at WIDTH = 4, 8 and 1. Stimulus
// pushes the arithmetic expectation ((a - b) mod 2^W, a < b) and the accept
// cycle; a negedge monitor pops on every valid_o and checks value, latency,
// pulse length and that results hold between pulses.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   typedef struct {
      logic [7:0] d;
      logic       b;
      int         acc;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   int         cyc = 0;
   int         n_checks = 0;
   int         n_fail = 0;

   logic       st4 = 1'b0;
   logic [3:0] a4 = 4'd0, b4 = 4'd0, d4;
   logic       rdy4, v4, bo4;
   logic       st8 = 1'b0;
   logic [7:0] a8 = 8'd0, b8 = 8'd0, d8;
   logic       rdy8, v8, bo8;
   logic       st1 = 1'b0;
   logic [0:0] a1 = 1'b0, b1 = 1'b0, d1;
   logic       rdy1, v1, bo1;

   exp_t       q[3][$];
   logic [7:0] hold_d[3] = '{8'd0, 8'd0, 8'd0};
   logic       hold_b[3] = '{1'b0, 1'b0, 1'b0};
   logic       prev_v[3] = '{1'b0, 1'b0, 1'b0};

   serial_subtractor #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start_i(st4), .a_i(a4), .b_i(b4),
      .ready_o(rdy4), .diff_o(d4), .borrow_o(bo4), .valid_o(v4));
   serial_subtractor #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start_i(st8), .a_i(a8), .b_i(b8),
      .ready_o(rdy8), .diff_o(d8), .borrow_o(bo8), .valid_o(v8));
   serial_subtractor #(.WIDTH(1)) u_dut1 (
      .clk(clk), .rst(rst), .start_i(st1), .a_i(a1), .b_i(b1),
      .ready_o(rdy1), .diff_o(d1), .borrow_o(bo1), .valid_o(v1));

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   function automatic int wid(input int k);
      case (k)
         0:       return 4;
         1:       return 8;
         default: return 1;
      endcase
   endfunction

   function automatic logic rdy_sel(input int k);
      case (k)
         0:       return rdy4;
         1:       return rdy8;
         default: return rdy1;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input int k, input logic s, input logic [7:0] a, input logic [7:0] b);
      case (k)
         0:       begin st4 = s; a4 = a[3:0]; b4 = b[3:0]; end
         1:       begin st8 = s; a8 = a;      b8 = b;      end
         default: begin st1 = s; a1 = a[0];   b1 = b[0];   end
      endcase
   endtask

   // Reference: plain modular subtraction and unsigned compare.
   task automatic push_exp(input int k, input logic [7:0] a, input logic [7:0] b);
      int   w, m, ai, bi;
      exp_t e;
      w     = wid(k);
      m     = (1 << w) - 1;
      ai    = int'(a) & m;
      bi    = int'(b) & m;
      e.d   = 8'((ai - bi) & m);
      e.b   = (ai < bi);
      e.acc = cyc;
      q[k].push_back(e);
   endtask

   // Wait (bounded) for ready, present one request for one edge.
   task automatic do_op(input int k, input logic [7:0] a, input logic [7:0] b);
      int   t;
      logic r;
      t = 0;
      @(negedge clk);
      r = rdy_sel(k);
      while (!r && t < 50) begin
         @(negedge clk);
         t++;
         r = rdy_sel(k);
      end
      if (!r) begin
         check($sformatf("w%0d_ready_timeout", wid(k)), {31'd0, r}, 32'd1);
         return;
      end
      drive(k, 1'b1, a, b);
      @(posedge clk);
      #1;
      push_exp(k, a, b);
      drive(k, 1'b0, 8'($urandom), 8'($urandom));
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         q[k].delete();
         hold_d[k] = 8'd0;
         hold_b[k] = 1'b0;
         prev_v[k] = 1'b0;
      end
      repeat (n) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic mon(input int k, input logic v, input logic [7:0] d, input logic bo);
      exp_t  e;
      string p;
      p = $sformatf("w%0d_", wid(k));
      if (v) begin
         check({p, "valid_pulse_len"}, {31'd0, prev_v[k]}, 32'd0);
         if (q[k].size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %sunexpected_valid: got valid with diff 0x%0h, expected no result (cycle %0d)",
                     p, d, cyc);
         end else begin
            e = q[k].pop_front();
            check({p, "diff"},    {24'd0, d},  {24'd0, e.d});
            check({p, "borrow"},  {31'd0, bo}, {31'd0, e.b});
            check({p, "latency"}, cyc,         e.acc + wid(k));
            hold_d[k] = e.d;
            hold_b[k] = e.b;
         end
      end else begin
         check({p, "diff_hold"},   {24'd0, d},  {24'd0, hold_d[k]});
         check({p, "borrow_hold"}, {31'd0, bo}, {31'd0, hold_b[k]});
      end
      prev_v[k] = v;
   endtask

   always @(negedge clk) begin
      if (rst) begin
         for (int k = 0; k < 3; k++) prev_v[k] = 1'b0;
      end else begin
         mon(0, v4, {4'd0, d4}, bo4);
         mon(1, v8, d8, bo8);
         mon(2, v1, {7'd0, d1}, bo1);
      end
   end

   initial begin
      #50000000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      do_reset(2);
      @(negedge clk);
      check("rst_ready4", {31'd0, rdy4}, 32'd1);
      check("rst_valid4", {31'd0, v4},   32'd0);
      check("rst_diff4",  {28'd0, d4},   32'd0);
      check("rst_borrow4",{31'd0, bo4},  32'd0);
      check("rst_ready8", {31'd0, rdy8}, 32'd1);
      check("rst_ready1", {31'd0, rdy1}, 32'd1);

      // 9 - 3 with handshake timing around DONE.
      do_op(0, 8'd9, 8'd3);
      repeat (3) @(posedge clk);
      #1;
      check("busy_not_ready", {31'd0, rdy4}, 32'd0);
      @(posedge clk);
      #1;
      check("done_valid",     {31'd0, v4},   32'd1);
      check("done_not_ready", {31'd0, rdy4}, 32'd0);
      @(posedge clk);
      #1;
      check("ready_after_done", {31'd0, rdy4}, 32'd1);
      check("valid_dropped",    {31'd0, v4},   32'd0);

      do_op(0, 8'd3, 8'd9);
      do_op(0, 8'd0, 8'd1);
      do_op(0, 8'd15, 8'd15);

      // Requests during BUSY and DONE must be ignored.
      do_op(0, 8'd9, 8'd3);
      drive(0, 1'b1, 8'd1, 8'd2);
      repeat (wid(0) + 1) @(posedge clk);
      #1;
      drive(0, 1'b0, 8'd0, 8'd0);
      repeat (8) @(posedge clk);
      #1;
      check("ignored_request_pending", q[0].size(), 32'd0);

      // Reset during the second BUSY cycle aborts the operation.
      do_op(0, 8'd5, 8'd7);
      @(posedge clk);
      #1;
      do_reset(1);
      @(negedge clk);
      check("abort_ready",  {31'd0, rdy4}, 32'd1);
      check("abort_valid",  {31'd0, v4},   32'd0);
      check("abort_diff",   {28'd0, d4},   32'd0);
      check("abort_borrow", {31'd0, bo4},  32'd0);
      repeat (8) @(posedge clk);

      // Back-to-back: start held high, second op accepted as soon as idle.
      do_op(0, 8'd12, 8'd5);
      drive(0, 1'b1, 8'd2, 8'd7);
      repeat (wid(0) + 1) @(posedge clk);
      #1;
      check("b2b_ready", {31'd0, rdy4}, 32'd1);
      @(posedge clk);
      #1;
      push_exp(0, 8'd2, 8'd7);
      drive(0, 1'b0, 8'd0, 8'd0);
      check("b2b_accepted", {31'd0, rdy4}, 32'd0);

      // WIDTH=1 directed case.
      do_op(2, 8'd0, 8'd1);

      for (int i = 0; i < 1000; i++) begin
         do_op(0, 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 3) == 0) @(posedge clk);
      end
      for (int i = 0; i < 1000; i++) begin
         do_op(1, 8'($urandom), 8'($urandom));
         if ($urandom_range(0, 3) == 0) @(posedge clk);
      end
      for (int i = 0; i < 100; i++) begin
         do_op(2, 8'($urandom), 8'($urandom));
      end

      repeat (20) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("w%0d_results_outstanding", wid(k)), q[k].size(), 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
